// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state codes, the NOP
// word and small PC helpers used by the fetch unit, the hazard unit and the bench.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Instruction addresses are word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_fetch_unit_register.sv
// Generic load-enable register with synchronous clear and synchronous reset.
// Priority: rst > sclr > ld.
module if_fetch_unit_register #(
  parameter int          W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         sclr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (sclr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, drives the req/ready instruction
// memory port and feeds the IF/ID register, absorbing stalls and redirects.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic [31:0] PcOut,
  output logic [31:0] InstOut,
  output logic        IfIdLoad,
  output logic        IfIdFlush,
  output logic [1:0]  dbg_state
);

  // Memory handshake: a fetch is outstanding whenever ImemReq=1; it completes
  // in the cycle ImemReady=1, and ImemAddr is held constant until then.

  fetch_state_e state, state_n;

  logic [31:0] pc, hold_inst, redir_pc;
  logic [31:0] pc_d, target;
  logic        pc_ld, hold_ld, hold_clr, redir_ld;

  assign target = align_pc(RedirectTarget);

  if_fetch_unit_register #(.W(32), .RST_VAL(RESET_PC)) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .ld   (pc_ld),
    .sclr (1'b0),
    .d    (pc_d),
    .q    (pc)
  );

  if_fetch_unit_register #(.W(32), .RST_VAL(NOP_WORD)) u_hold_reg (
    .clk  (clk),
    .rst  (rst),
    .ld   (hold_ld),
    .sclr (hold_clr),
    .d    (ImemData),
    .q    (hold_inst)
  );

  if_fetch_unit_register #(.W(32), .RST_VAL(32'h0000_0000)) u_redir_reg (
    .clk  (clk),
    .rst  (rst),
    .ld   (redir_ld),
    .sclr (1'b0),
    .d    (target),
    .q    (redir_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_ld     = 1'b0;
    pc_d      = next_seq_pc(pc);
    hold_ld   = 1'b0;
    hold_clr  = 1'b0;
    redir_ld  = 1'b0;
    ImemReq   = 1'b0;
    IfIdLoad  = 1'b0;
    IfIdFlush = 1'b0;

    if (rst) begin
      IfIdFlush = 1'b1;
    end else begin
      unique case (state)
        FETCH: begin
          ImemReq = 1'b1;
          if (ImemReady) begin
            if (Redirect) begin
              pc_d      = target;
              pc_ld     = 1'b1;
              IfIdFlush = 1'b1;
            end else if (Stall) begin
              hold_ld = 1'b1;
              state_n = HOLD;
            end else begin
              pc_ld    = 1'b1;
              IfIdLoad = 1'b1;
            end
          end else begin
            // Address must not move while the request is outstanding; a
            // redirect is parked in redir_pc until the stale response drains.
            if (Redirect) begin
              redir_ld  = 1'b1;
              IfIdFlush = 1'b1;
              state_n   = DROP;
            end else if (!Stall) begin
              IfIdFlush = 1'b1;
            end
          end
        end

        HOLD: begin
          if (Redirect) begin
            pc_d      = target;
            pc_ld     = 1'b1;
            hold_clr  = 1'b1;
            IfIdFlush = 1'b1;
            state_n   = FETCH;
          end else if (!Stall) begin
            pc_ld    = 1'b1;
            IfIdLoad = 1'b1;
            state_n  = FETCH;
          end
        end

        DROP: begin
          ImemReq   = 1'b1;
          IfIdFlush = 1'b1;
          redir_ld  = Redirect;
          if (ImemReady) begin
            pc_d    = Redirect ? target : redir_pc;
            pc_ld   = 1'b1;
            state_n = FETCH;
          end
        end

        default: begin
          state_n = FETCH;
        end
      endcase
    end
  end

  assign ImemAddr  = pc;
  assign PcOut     = next_seq_pc(pc);
  assign InstOut   = (state == HOLD) ? hold_inst : ImemData;
  assign dbg_state = state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by random
// stall/redirect/ready traffic, checked cycle by cycle against a behavioural model.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemData;
  logic [31:0] PcOut;
  logic [31:0] InstOut;
  logic        IfIdLoad;
  logic        IfIdFlush;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: PC, a held word (valid while holding), and a pending
  // redirect target that applies once the stale response drains.
  logic [31:0] m_pc;
  logic [31:0] m_hold;
  logic [31:0] m_pend;
  bit          m_holding;
  bit          m_draining;
  bit          m_known;

  logic [31:0] exp_q[$];

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .ImemReq        (ImemReq),
    .ImemAddr       (ImemAddr),
    .ImemReady      (ImemReady),
    .ImemData       (ImemData),
    .PcOut          (PcOut),
    .InstOut        (InstOut),
    .IfIdLoad       (IfIdLoad),
    .IfIdFlush      (IfIdFlush),
    .dbg_state      (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, check outputs mid-cycle, advance model.
  task automatic run_cycle(input bit r, input bit st, input bit rd,
                           input logic [31:0] tgt, input bit rdy);
    bit          e_req, e_load, e_flush;
    logic [31:0] e_inst;
    logic [31:0] data;
    logic [31:0] t;
    fetch_state_e e_state;

    data = rdy ? mem_word(m_pc) : $urandom();
    rst            = r;
    Stall          = st;
    Redirect       = rd;
    RedirectTarget = tgt;
    ImemReady      = rdy;
    ImemData       = data;
    t = tgt & 32'hFFFF_FFFC;

    e_req = 0; e_load = 0; e_flush = 0; e_inst = 32'h0;
    if (r) begin
      e_flush = 1;
    end else if (m_holding) begin
      if (rd) e_flush = 1;
      else if (!st) begin e_load = 1; e_inst = m_hold; end
    end else if (m_draining) begin
      e_req = 1; e_flush = 1;
    end else begin
      e_req = 1;
      if (rd) e_flush = 1;
      else if (st) e_flush = 0;
      else if (rdy) begin e_load = 1; e_inst = data; end
      else e_flush = 1;
    end
    if (e_load) exp_q.push_back(e_inst);
    e_state = m_holding ? HOLD : (m_draining ? DROP : FETCH);

    @(negedge clk);
    check_eq("imem_req", 32'(ImemReq), 32'(e_req));
    check_eq("ifid_load", 32'(IfIdLoad), 32'(e_load));
    check_eq("ifid_flush", 32'(IfIdFlush), 32'(e_flush));
    check_eq("load_flush_excl", 32'(IfIdLoad & IfIdFlush), 32'd0);
    if (m_known && !r) begin
      check_eq("imem_addr", ImemAddr, m_pc);
      check_eq("pc_out", PcOut, m_pc + 32'd4);
      check_eq("fsm_state", 32'(dbg_state), 32'(e_state));
    end
    if (IfIdLoad) begin
      if (exp_q.size() > 0) check_eq("inst_out", InstOut, exp_q.pop_front());
      else check_eq("inst_q_empty", 32'(exp_q.size()), 32'd1);
    end

    if (r) begin
      m_pc = RST_PC; m_hold = 32'h0; m_pend = 32'h0;
      m_holding = 0; m_draining = 0; m_known = 1;
    end else if (m_holding) begin
      if (rd) begin m_pc = t; m_holding = 0; end
      else if (!st) begin m_pc = m_pc + 32'd4; m_holding = 0; end
    end else if (m_draining) begin
      if (rd) m_pend = t;
      if (rdy) begin m_pc = m_pend; m_draining = 0; end
    end else if (rdy) begin
      if (rd) m_pc = t;
      else if (st) begin m_hold = data; m_holding = 1; end
      else m_pc = m_pc + 32'd4;
    end else if (rd) begin
      m_pend = t; m_draining = 1;
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; Stall = 0; Redirect = 0; RedirectTarget = 0; ImemReady = 0; ImemData = 0;
    m_pc = 0; m_hold = 0; m_pend = 0; m_holding = 0; m_draining = 0; m_known = 0;
    #1;

    // Reset, then zero-wait streaming
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 1);

    // Memory ready after three cycles
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 1);

    // Stall on the ready cycle at 0x100, held three cycles
    run_cycle(0, 0, 1, 32'h0000_0101, 1);
    run_cycle(0, 1, 0, 0, 1);
    run_cycle(0, 1, 0, 0, 0);
    run_cycle(0, 1, 0, 0, 1);
    run_cycle(0, 0, 0, 0, 0);
    check_eq("addr_after_hold", ImemAddr, 32'h0000_0104);

    // Redirect to 0x2000 while the fetch at 0x104 is pending
    run_cycle(0, 0, 1, 32'h0000_2000, 0);
    run_cycle(0, 1, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 1);
    check_eq("addr_after_drop", ImemAddr, 32'h0000_2000);

    // Redirect and Stall together while holding
    run_cycle(0, 1, 0, 0, 1);
    run_cycle(0, 1, 1, 32'h0000_3000, 0);
    check_eq("addr_hold_redirect", ImemAddr, 32'h0000_3000);

    // PC wrap, then reset in the middle of a wait
    run_cycle(0, 0, 1, 32'hFFFF_FFFF, 1);
    run_cycle(0, 0, 0, 0, 1);
    check_eq("addr_wrap", ImemAddr, 32'h0000_0000);
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 1, 32'h0000_5000, 0);
    run_cycle(1, 0, 0, 0, 1);
    check_eq("addr_after_rst", ImemAddr, RST_PC);
    check_eq("state_after_rst", 32'(dbg_state), 32'(FETCH));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit          r, st, rd, rdy;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 99) < 15);
      rdy = ($urandom_range(0, 99) < 60);
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom();
      run_cycle(r, st, rd, tgt, rdy);
    end

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
